// File: rtl/branch_unit_pkg.sv
// Shared encodings and types for the branch unit: op/condition codes,
// PC-source selects, BHT reset state and the NZCV flag bundle.
package branch_unit_pkg;

  localparam logic [2:0] BCOND_OP_NONE   = 3'd0;
  localparam logic [2:0] BCOND_OP_BRANCH = 3'd1;
  localparam logic [2:0] BCOND_OP_ALU    = 3'd2;
  localparam logic [2:0] BCOND_OP_NOINC  = 3'd3;
  localparam logic [2:0] BCOND_OP_ZERO   = 3'd4;
  localparam logic [2:0] BCOND_OP_NZERO  = 3'd5;
  localparam logic [2:0] BCOND_OP_COND   = 3'd6;

  localparam logic [4:0] BCOND_EQ = 5'd0;
  localparam logic [4:0] BCOND_NE = 5'd1;
  localparam logic [4:0] BCOND_CS = 5'd2;
  localparam logic [4:0] BCOND_CC = 5'd3;
  localparam logic [4:0] BCOND_MI = 5'd4;
  localparam logic [4:0] BCOND_PL = 5'd5;
  localparam logic [4:0] BCOND_VS = 5'd6;
  localparam logic [4:0] BCOND_VC = 5'd7;
  localparam logic [4:0] BCOND_HI = 5'd8;
  localparam logic [4:0] BCOND_LS = 5'd9;
  localparam logic [4:0] BCOND_GE = 5'd10;
  localparam logic [4:0] BCOND_LT = 5'd11;
  localparam logic [4:0] BCOND_GT = 5'd12;
  localparam logic [4:0] BCOND_LE = 5'd13;
  localparam logic [4:0] BCOND_AL = 5'd14;
  localparam logic [4:0] BCOND_NV = 5'd15;

  localparam logic [1:0] BRANCH_SRC_INC    = 2'b00;
  localparam logic [1:0] BRANCH_SRC_TARGET = 2'b01;
  localparam logic [1:0] BRANCH_SRC_ALU    = 2'b10;
  localparam logic [1:0] BRANCH_SRC_HOLD   = 2'b11;

  localparam logic [1:0] BHT_RESET_STATE = 2'b01;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // 2-bit saturating up/down step for the history counters.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] nxt;
    nxt = cnt;
    if (up && cnt != 2'b11)       nxt = cnt + 2'b01;
    else if (!up && cnt != 2'b00) nxt = cnt - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator: 5-bit condition plus NZCV gives
// a single "condition holds" bit. Undefined codes never hold.
module branch_cond_eval
  import branch_unit_pkg::*;
(
  input  logic [4:0] cond,
  input  nzcv_t      flags,
  output logic       holds
);

  always_comb begin
    holds = 1'b0;
    case (cond)
      BCOND_EQ: holds = flags.z;
      BCOND_NE: holds = !flags.z;
      BCOND_CS: holds = flags.c;
      BCOND_CC: holds = !flags.c;
      BCOND_MI: holds = flags.n;
      BCOND_PL: holds = !flags.n;
      BCOND_VS: holds = flags.v;
      BCOND_VC: holds = !flags.v;
      BCOND_HI: holds = flags.c && !flags.z;
      BCOND_LS: holds = !flags.c || flags.z;
      BCOND_GE: holds = (flags.n == flags.v);
      BCOND_LT: holds = (flags.n != flags.v);
      BCOND_GT: holds = !flags.z && (flags.n == flags.v);
      BCOND_LE: holds = flags.z || (flags.n != flags.v);
      BCOND_AL: holds = 1'b1;
      default:  holds = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution at the EX/MEM boundary: NZCV register, PC-source select,
// bimodal history table with lookup/update ports, mispredict statistics.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int PC_WIDTH     = 64,
  parameter int BHT_IDX_BITS = 6,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_taken,
  input  logic                 valid,
  input  logic                 stall,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [2:0]           branch_op,
  input  logic [4:0]           conditional_branch,
  input  logic                 predicted,
  input  logic                 set_flags,
  input  logic                 zero,
  input  logic                 negative,
  input  logic                 overflow,
  input  logic                 carry,
  output logic [1:0]           branch_src,
  output logic                 mispredict,
  output logic [3:0]           flags,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  nzcv_t alu_flags, eff_flags, flags_q, flags_d;
  logic  cond_holds, eligible, taken, upd;
  logic [BHT_IDX_BITS-1:0] lookup_idx, upd_idx;
  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic pc_unused;

  assign alu_flags = '{n: negative, z: zero, c: carry, v: overflow};
  // Same-cycle bypass so a flag-setting op can feed its own conditional branch.
  assign eff_flags = (valid && set_flags) ? alu_flags : flags_q;

  branch_cond_eval u_cond (
    .cond  (conditional_branch),
    .flags (eff_flags),
    .holds (cond_holds)
  );

  always_comb begin
    branch_src = BRANCH_SRC_INC;
    if (valid) begin
      case (branch_op)
        BCOND_OP_BRANCH: branch_src = BRANCH_SRC_TARGET;
        BCOND_OP_ALU:    branch_src = BRANCH_SRC_ALU;
        BCOND_OP_NOINC:  branch_src = BRANCH_SRC_HOLD;
        BCOND_OP_ZERO:   branch_src = zero  ? BRANCH_SRC_TARGET : BRANCH_SRC_INC;
        BCOND_OP_NZERO:  branch_src = !zero ? BRANCH_SRC_TARGET : BRANCH_SRC_INC;
        BCOND_OP_COND:   branch_src = cond_holds ? BRANCH_SRC_TARGET : BRANCH_SRC_INC;
        default:         branch_src = BRANCH_SRC_INC;
      endcase
    end
  end

  assign eligible   = valid && (branch_op == BCOND_OP_ZERO || branch_op == BCOND_OP_NZERO ||
                                branch_op == BCOND_OP_COND);
  assign taken      = (branch_src == BRANCH_SRC_TARGET);
  assign mispredict = eligible && (taken != predicted);
  assign upd        = eligible && !stall;

  assign lookup_idx = lookup_pc[BHT_IDX_BITS+1:2];
  assign upd_idx    = pc[BHT_IDX_BITS+1:2];
  // Reads the registered table: a same-index update is not visible until next cycle.
  assign pred_taken = bht_q[lookup_idx][1];
  assign pc_unused  = ^{lookup_pc[PC_WIDTH-1:BHT_IDX_BITS+2], lookup_pc[1:0],
                        pc[PC_WIDTH-1:BHT_IDX_BITS+2], pc[1:0]};

  always_comb begin
    flags_d            = flags_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    for (int i = 0; i < BHT_ENTRIES; i++) bht_d[i] = bht_q[i];
    if (valid && set_flags && !stall) flags_d = alu_flags;
    if (upd) begin
      bht_d[upd_idx] = sat_step(bht_q[upd_idx], taken);
      if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + CNT_WIDTH'(1);
      if (mispredict && mispredict_count_q != CNT_MAX)
        mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET_STATE;
    end else begin
      flags_q            <= flags_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

  assign flags            = flags_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: a default-width instance plus a
// CNT_WIDTH=4 instance sharing the same stimulus for counter saturation.
module tb_branch_unit;
  import branch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] lookup_pc, pc;
  logic        valid, stall, predicted, set_flags;
  logic        zero, negative, overflow, carry;
  logic [2:0]  branch_op;
  logic [4:0]  conditional_branch;

  logic        pred_taken, mispredict, pred_taken4, mispredict4;
  logic [1:0]  branch_src, branch_src4;
  logic [3:0]  flags, flags4;
  logic [31:0] branch_count, mispredict_count;
  logic [3:0]  branch_count4, mispredict_count4;

  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .valid(valid), .stall(stall), .pc(pc), .branch_op(branch_op),
    .conditional_branch(conditional_branch), .predicted(predicted), .set_flags(set_flags),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .branch_src(branch_src), .mispredict(mispredict), .flags(flags),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc), .pred_taken(pred_taken4),
    .valid(valid), .stall(stall), .pc(pc), .branch_op(branch_op),
    .conditional_branch(conditional_branch), .predicted(predicted), .set_flags(set_flags),
    .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
    .branch_src(branch_src4), .mispredict(mispredict4), .flags(flags4),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition reference: even codes give a base test, odd codes invert it.
  function automatic logic ref_cond(input logic [4:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return c[4] ? 1'b0 : (base ^ c[0]);
  endfunction

  task automatic alu(input logic [3:0] nzcv);
    {negative, zero, carry, overflow} = nzcv;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; lookup_pc = 64'h100; pc = '0; valid = 0; stall = 0; predicted = 0;
    set_flags = 0; branch_op = BCOND_OP_NONE; conditional_branch = BCOND_EQ; alu(4'b0000);
    post_edge(); post_edge();
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("rst_pred", pred_taken, 0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_bc", branch_count, 0);
    chk("rst_mc", mispredict_count, 0);
    chk("idle_src", branch_src, 2'b00);

    // Four taken ZERO branches at 0x100, then two not-taken.
    @(negedge clk); valid = 1; pc = 64'h100; branch_op = BCOND_OP_ZERO; alu(4'b0100); predicted = 0;
    #1; chk("zero_src", branch_src, 2'b01); chk("zero_misp", mispredict, 1);
    post_edge(); chk("bht_1upd", pred_taken, 1); chk("bc_1", branch_count, 1); chk("mc_1", mispredict_count, 1);
    @(negedge clk); predicted = 1; #1; chk("zero_hit", mispredict, 0);
    post_edge(); chk("bht_2upd", pred_taken, 1);
    @(negedge clk); post_edge();
    @(negedge clk); post_edge();
    @(negedge clk); alu(4'b0000); #1; chk("zero_nt_src", branch_src, 2'b00); chk("zero_nt_misp", mispredict, 1);
    post_edge(); chk("bht_sat_dec1", pred_taken, 1);
    @(negedge clk); post_edge(); chk("bht_sat_dec2", pred_taken, 0);
    chk("bc_6", branch_count, 6); chk("mc_3", mispredict_count, 3);

    // Flag bypass then registered flags.
    @(negedge clk); pc = 64'h204; branch_op = BCOND_OP_COND; conditional_branch = BCOND_LT;
    set_flags = 1; alu(4'b1000); predicted = 1;
    #1; chk("lt_bypass", branch_src, 2'b01); chk("lt_misp", mispredict, 0);
    post_edge(); chk("flags_load", flags, 4'b1000);
    @(negedge clk); pc = 64'h208; conditional_branch = BCOND_GE; set_flags = 0; alu(4'b0000); predicted = 0;
    #1; chk("ge_reg", branch_src, 2'b00); chk("ge_misp", mispredict, 0);
    post_edge(); chk("flags_keep", flags, 4'b1000); chk("bc_8", branch_count, 8);

    // Condition sweep under stall, flags via bypass.
    @(negedge clk); stall = 1; set_flags = 1;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        conditional_branch = 5'(c); alu(4'(f));
        #1; chk($sformatf("cond%0d_f%0h", c, f), branch_src, {1'b0, ref_cond(5'(c), 4'(f))});
      end
    end
    conditional_branch = BCOND_LS; alu(4'b0000); #1; chk("ls_c0z0", branch_src, 2'b01);
    alu(4'b0010); #1; chk("ls_c1z0", branch_src, 2'b00);
    conditional_branch = 5'd20; alu(4'b1111); #1; chk("undef_cond", branch_src, 2'b00);
    post_edge(); chk("sweep_flags", flags, 4'b1000); chk("sweep_bc", branch_count, 8);

    // EQ not-taken mispredict, then unconditional BRANCH.
    @(negedge clk); stall = 0; set_flags = 0; pc = 64'h20C; conditional_branch = BCOND_EQ;
    alu(4'b0100); predicted = 1;
    #1; chk("eq_src", branch_src, 2'b00); chk("eq_misp", mispredict, 1);
    post_edge(); chk("bc_9", branch_count, 9); chk("mc_4", mispredict_count, 4);
    @(negedge clk); pc = 64'h210; branch_op = BCOND_OP_BRANCH; predicted = 0;
    #1; chk("br_src", branch_src, 2'b01); chk("br_misp", mispredict, 0);
    post_edge(); chk("br_bc", branch_count, 9); chk("br_mc", mispredict_count, 4);

    // Stall freezes flags, BHT and counters.
    @(negedge clk); pc = 64'h3F0; lookup_pc = 64'h3F0; branch_op = BCOND_OP_COND;
    conditional_branch = BCOND_AL; set_flags = 1; alu(4'b0111); predicted = 0; stall = 1;
    #1; chk("stall_src", branch_src, 2'b01); chk("stall_misp", mispredict, 1); chk("stall_pred0", pred_taken, 0);
    post_edge(); chk("stall_flags", flags, 4'b1000); chk("stall_bc", branch_count, 9);
    chk("stall_mc", mispredict_count, 4); chk("stall_bht", pred_taken, 0);

    // Same-index lookup during update sees the old value.
    @(negedge clk); stall = 0; set_flags = 0; predicted = 1;
    #1; chk("nobypass_pre", pred_taken, 0);
    post_edge(); chk("nobypass_post", pred_taken, 1); chk("bc_10", branch_count, 10);

    // Twenty mispredicted branches saturate the 4-bit counters.
    @(negedge clk); pc = 64'h10; conditional_branch = BCOND_NV; predicted = 1;
    for (int i = 0; i < 20; i++) begin
      post_edge();
      @(negedge clk);
    end
    chk("sat_bc4", branch_count4, 4'hF); chk("sat_mc4", mispredict_count4, 4'hF);
    chk("bc_30", branch_count, 30); chk("mc_24", mispredict_count, 24);

    // Reset during an active flag-setting, table-updating branch.
    pc = 64'h3F0; conditional_branch = BCOND_AL; set_flags = 1; alu(4'b1111); predicted = 0;
    reset_n = 0;
    post_edge();
    chk("mid_rst_flags", flags, 4'b0000); chk("mid_rst_bc", branch_count, 0);
    chk("mid_rst_mc", mispredict_count, 0); chk("mid_rst_bht", pred_taken, 0);
    chk("mid_rst_bc4", branch_count4, 0); chk("mid_rst_mc4", mispredict_count4, 0);

    @(negedge clk); reset_n = 1; valid = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
